tdm_demultiplexer: RTL

Serial time-division demultiplexer, the receive end of the team's multiplexer path. It takes a single-bit serial stream carrying NCH fixed-width channel slots per frame and a frame-sync marker. It deserialises each slot MSB-first and distributes it to a per-channel parallel holding register. It sits after the serial link input and feeds the per-channel consumers. It also reports lock, per-slot strobes and sync errors.

---
 rtl/tdm_pkg.sv | 25 ++
 rtl/tdm_deser.sv | 74 +++++++
 rtl/tdm_demultiplexer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and width helpers for the TDM demultiplexer.
// TDM_DEMUX_PARITY_EN selects an extra even-parity bit per slot.
package tdm_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int slot_bits(input int w);
    return w + PAR_BITS;
  endfunction

endpackage

// File: rtl/tdm_deser.sv
// Slot deserialiser: MSB-first shift register, bit counter, completion flag
// and optional even-parity check (TDM_DEMUX_PARITY_EN).
module tdm_deser
  import tdm_pkg::*;
#(
  parameter int W  = 8,
  parameter int SB = slot_bits(W),
  parameter int CW = cnt_width(SB)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          restart_i,
  input  logic          d_i,
  output logic [W-1:0]  word_o,
  output logic          done_o,
  output logic          par_err_o,
  output logic [CW-1:0] bit_cnt_o
);

  localparam int SR_W = SB - 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(SB - 1);

  logic [SR_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SB-1:0]   full_s;

  // The word completes on the edge that samples its last bit, so the
  // incoming bit is appended combinationally rather than waiting a cycle.
  always_comb begin
    full_s = {shreg_q, d_i};
    word_o = full_s[SB-1 -: W];
    done_o = en_i && !restart_i && (bit_cnt_q == LAST_BIT);
`ifdef TDM_DEMUX_PARITY_EN
    par_err_o = done_o && (^full_s);
`else
    par_err_o = 1'b0;
`endif
  end

  // Next shift-register and bit-counter values.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (restart_i) begin
      shreg_d   = SR_W'(d_i);
      bit_cnt_d = CW'(1);
    end else if (en_i) begin
      shreg_d = full_s[SR_W-1:0];
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = {CW{1'b0}};
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end else begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Deserialiser state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= {SR_W{1'b0}};
      bit_cnt_q <= {CW{1'b0}};
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_cnt_o = bit_cnt_q;

endmodule

// File: rtl/tdm_demultiplexer.sv
// Serial TDM demultiplexer: frame lock FSM, slot counter, per-channel
// holding registers and strobes. Parity build: TDM_DEMUX_PARITY_EN.
module tdm_demultiplexer
  import tdm_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        D,
  input  logic                        FS,
  output logic [NCH*W-1:0]            Y,
  output logic                        SLOT_STB,
  output logic [cnt_width(NCH)-1:0]   SLOT,
  output logic                        FRAME_STB,
  output logic                        LOCKED,
  output logic                        SYNC_ERR,
  output logic                        PAR_ERR
);

  localparam int SB = slot_bits(W);
  localparam int CW = cnt_width(SB);
  localparam int SW = cnt_width(NCH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);

  state_e state_q, state_d;

  logic [SW-1:0]    slot_cnt_q, slot_cnt_d;
  logic [NCH*W-1:0] y_q, y_d;
  logic             slot_stb_q, slot_stb_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic             frame_stb_q, frame_stb_d;
  logic             locked_q, locked_d;
  logic             sync_err_q, sync_err_d;
  logic             par_err_q, par_err_d;

  logic             en_s;
  logic             frame_start_s;
  logic [W-1:0]     word_s;
  logic             word_done_s;
  logic             word_par_err_s;
  logic [CW-1:0]    bit_cnt_s;

  // Every FS restarts the deserialiser; at the expected frame start that
  // is indistinguishable from the normal slot boundary.
  always_comb begin
    en_s          = (state_q == RUN) || FS;
    frame_start_s = (state_q == RUN) && (bit_cnt_s == {CW{1'b0}}) &&
                    (slot_cnt_q == {SW{1'b0}});
  end

  tdm_deser #(
    .W  (W),
    .SB (SB),
    .CW (CW)
  ) u_deser (
    .clk       (CLK),
    .rst_n     (RST_N),
    .en_i      (en_s),
    .restart_i (FS),
    .d_i       (D),
    .word_o    (word_s),
    .done_o    (word_done_s),
    .par_err_o (word_par_err_s),
    .bit_cnt_o (bit_cnt_s)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: once locked, only reset returns to HUNT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    state_d = FS ? RUN : HUNT;
      RUN:     state_d = RUN;
      default: state_d = HUNT;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    y_d         = y_q;
    slot_cnt_d  = slot_cnt_q;
    slot_d      = slot_q;
    slot_stb_d  = word_done_s;
    frame_stb_d = word_done_s && (slot_cnt_q == LAST_SLOT);
    par_err_d   = word_par_err_s;
    locked_d    = (state_d == RUN);
    sync_err_d  = (state_q == RUN) && FS && !frame_start_s;

    if (FS) begin
      slot_cnt_d = {SW{1'b0}};
    end else if (word_done_s) begin
      slot_cnt_d = (slot_cnt_q == LAST_SLOT) ? {SW{1'b0}} : slot_cnt_q + SW'(1);
    end else begin
      slot_cnt_d = slot_cnt_q;
    end

    if (word_done_s) begin
      slot_d = slot_cnt_q;
    end else begin
      slot_d = slot_q;
    end

    for (int k = 0; k < NCH; k++) begin
      if (word_done_s && !word_par_err_s && (slot_cnt_q == SW'(k))) begin
        y_d[k*W +: W] = word_s;
      end else begin
        y_d[k*W +: W] = y_q[k*W +: W];
      end
    end
  end

  // Registered outputs, slot counter and channel holding registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_q         <= {(NCH*W){1'b0}};
      slot_cnt_q  <= {SW{1'b0}};
      slot_q      <= {SW{1'b0}};
      slot_stb_q  <= 1'b0;
      frame_stb_q <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      y_q         <= y_d;
      slot_cnt_q  <= slot_cnt_d;
      slot_q      <= slot_d;
      slot_stb_q  <= slot_stb_d;
      frame_stb_q <= frame_stb_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
      par_err_q   <= par_err_d;
    end
  end

  assign Y         = y_q;
  assign SLOT_STB  = slot_stb_q;
  assign SLOT      = slot_q;
  assign FRAME_STB = frame_stb_q;
  assign LOCKED    = locked_q;
  assign SYNC_ERR  = sync_err_q;
  assign PAR_ERR   = par_err_q;

endmodule
